cpu_multicycle: RTL and testbench

Parametrised successor to the team's 4-bit single-cycle CPU. It keeps the same register set (A, B, OUT, IP, carry) and instruction semantics, and adds the following:
- configurable data and address widths;
- a two-phase fetch/execute state machine with a ready/valid program-memory handshake, so memory may insert wait states;
- a HLT instruction with a `halted` status output.

It sits between program memory, the switch inputs and the LED outputs on the mother board.

---
 rtl/cpu_multicycle.sv | 175 +++++++++++++++++
 tb/tb_cpu_multicycle.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/cpu_multicycle.sv
// ============================================================================
// Module   : cpu_multicycle
// Brief    : Parametrised multicycle accumulator CPU with fetch/execute FSM,
//            ready/valid program-memory handshake and a HLT instruction.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module cpu_multicycle #(
    parameter int DATA_W = 4,
    parameter int ADDR_W = 4
) (
    input  logic                clk,
    input  logic                reset_n,
    output logic                mem_req,
    output logic [ADDR_W-1:0]   mem_addr,
    input  logic [DATA_W+3:0]   mem_rdata,
    input  logic                mem_ready,
    input  logic [DATA_W-1:0]   switch,
    output logic [DATA_W-1:0]   led,
    output logic                halted
);

    localparam logic [3:0] c_OP_ADD_A  = 4'b0000;
    localparam logic [3:0] c_OP_MOV_AB = 4'b0001;
    localparam logic [3:0] c_OP_IN_A   = 4'b0010;
    localparam logic [3:0] c_OP_MOV_AI = 4'b0011;
    localparam logic [3:0] c_OP_MOV_BA = 4'b0100;
    localparam logic [3:0] c_OP_ADD_B  = 4'b0101;
    localparam logic [3:0] c_OP_IN_B   = 4'b0110;
    localparam logic [3:0] c_OP_MOV_BI = 4'b0111;
    localparam logic [3:0] c_OP_OUT_B  = 4'b1001;
    localparam logic [3:0] c_OP_OUT_I  = 4'b1011;
    localparam logic [3:0] c_OP_HLT    = 4'b1101;
    localparam logic [3:0] c_OP_JNC    = 4'b1110;
    localparam logic [3:0] c_OP_JMP    = 4'b1111;

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_EXEC  = 2'd1,
        S_HALT  = 2'd2
    } state_t;

    state_t              r_state;
    logic [DATA_W+3:0]   r_ir;
    logic [ADDR_W-1:0]   r_ip;
    logic [DATA_W-1:0]   r_a;
    logic [DATA_W-1:0]   r_b;
    logic [DATA_W-1:0]   r_out;
    logic                r_carry;
    logic                r_mem_req;
    logic                r_halted;

    logic [3:0]          w_opcode;
    logic [DATA_W-1:0]   w_imm;
    logic [DATA_W:0]     w_sum_a;
    logic [DATA_W:0]     w_sum_b;
    logic [ADDR_W-1:0]   w_ip_inc;
    logic [ADDR_W-1:0]   w_jmp_tgt;

    logic [DATA_W-1:0]   w_a_nxt;
    logic [DATA_W-1:0]   w_b_nxt;
    logic [DATA_W-1:0]   w_out_nxt;
    logic                w_carry_nxt;
    logic [ADDR_W-1:0]   w_ip_nxt;
    logic                w_hlt;

    assign w_opcode = r_ir[DATA_W+3:DATA_W];
    assign w_imm    = r_ir[DATA_W-1:0];
    assign w_sum_a  = {1'b0, r_a} + {1'b0, w_imm};
    assign w_sum_b  = {1'b0, r_b} + {1'b0, w_imm};
    assign w_ip_inc = r_ip + ADDR_W'(1);

    // Jump target: immediate zero-extended or truncated to the address width.
    generate
        if (ADDR_W == DATA_W) begin : g_jmp_eq
            assign w_jmp_tgt = w_imm;
        end else if (ADDR_W > DATA_W) begin : g_jmp_zext
            assign w_jmp_tgt = {{(ADDR_W-DATA_W){1'b0}}, w_imm};
        end else begin : g_jmp_trunc
            assign w_jmp_tgt = w_imm[ADDR_W-1:0];
        end
    endgenerate

    // Carry defaults to cleared: only the two ADD forms produce one.
    always_comb begin
        w_a_nxt     = r_a;
        w_b_nxt     = r_b;
        w_out_nxt   = r_out;
        w_carry_nxt = 1'b0;
        w_ip_nxt    = w_ip_inc;
        w_hlt       = 1'b0;
        case (w_opcode)
            c_OP_ADD_A: begin
                w_a_nxt     = w_sum_a[DATA_W-1:0];
                w_carry_nxt = w_sum_a[DATA_W];
            end
            c_OP_MOV_AB: w_a_nxt = r_b;
            c_OP_IN_A:   w_a_nxt = switch;
            c_OP_MOV_AI: w_a_nxt = w_imm;
            c_OP_MOV_BA: w_b_nxt = r_a;
            c_OP_ADD_B: begin
                w_b_nxt     = w_sum_b[DATA_W-1:0];
                w_carry_nxt = w_sum_b[DATA_W];
            end
            c_OP_IN_B:   w_b_nxt   = switch;
            c_OP_MOV_BI: w_b_nxt   = w_imm;
            c_OP_OUT_B:  w_out_nxt = r_b;
            c_OP_OUT_I:  w_out_nxt = w_imm;
            c_OP_JNC: begin
                if (!r_carry) begin
                    w_ip_nxt = w_jmp_tgt;
                end
            end
            c_OP_JMP:    w_ip_nxt  = w_jmp_tgt;
            c_OP_HLT: begin
                w_ip_nxt = r_ip;
                w_hlt    = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state   <= S_FETCH;
            r_ir      <= '0;
            r_ip      <= '0;
            r_a       <= '0;
            r_b       <= '0;
            r_out     <= '0;
            r_carry   <= 1'b0;
            r_mem_req <= 1'b1;
            r_halted  <= 1'b0;
        end else begin
            case (r_state)
                S_FETCH: begin
                    if (mem_ready) begin
                        r_ir      <= mem_rdata;
                        r_state   <= S_EXEC;
                        r_mem_req <= 1'b0;
                    end
                end
                S_EXEC: begin
                    r_a     <= w_a_nxt;
                    r_b     <= w_b_nxt;
                    r_out   <= w_out_nxt;
                    r_carry <= w_carry_nxt;
                    r_ip    <= w_ip_nxt;
                    if (w_hlt) begin
                        r_state  <= S_HALT;
                        r_halted <= 1'b1;
                    end else begin
                        r_state   <= S_FETCH;
                        r_mem_req <= 1'b1;
                    end
                end
                S_HALT: ;
                default: begin
                    r_state   <= S_FETCH;
                    r_mem_req <= 1'b1;
                    r_halted  <= 1'b0;
                end
            endcase
        end
    end

    assign mem_req  = r_mem_req;
    assign mem_addr = r_ip;
    assign led      = r_out;
    assign halted   = r_halted;

endmodule

`default_nettype wire

// File: tb/tb_cpu_multicycle.sv
// ============================================================================
// Module   : tb_cpu_multicycle
// Brief    : Directed self-checking bench for cpu_multicycle (4-bit and 8-bit).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cpu_multicycle;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;

    logic        req4, ready4, halted4;
    logic [3:0]  addr4, led4;
    logic [3:0]  switch4 = 4'h0;
    logic [7:0]  mem4 [0:15];
    int          wait4 = 1000;
    int          wcnt4;

    logic        req8, halted8;
    logic [3:0]  addr8;
    logic [7:0]  led8;
    logic [7:0]  switch8 = 8'h11;
    logic [11:0] mem8 [0:15];

    int          n_checks = 0;
    int          n_errors = 0;

    always #5 clk = ~clk;

    cpu_multicycle #(.DATA_W(4), .ADDR_W(4)) dut4 (
        .clk       (clk),
        .reset_n   (reset_n),
        .mem_req   (req4),
        .mem_addr  (addr4),
        .mem_rdata (mem4[addr4]),
        .mem_ready (ready4),
        .switch    (switch4),
        .led       (led4),
        .halted    (halted4)
    );

    cpu_multicycle #(.DATA_W(8), .ADDR_W(4)) dut8 (
        .clk       (clk),
        .reset_n   (reset_n),
        .mem_req   (req8),
        .mem_addr  (addr8),
        .mem_rdata (mem8[addr8]),
        .mem_ready (1'b1),
        .switch    (switch8),
        .led       (led8),
        .halted    (halted8)
    );

    // Memory with a programmable number of wait cycles before each accept.
    assign ready4 = (wcnt4 >= wait4);
    always @(posedge clk) begin
        if (!reset_n)            wcnt4 <= 0;
        else if (req4 && ready4) wcnt4 <= 0;
        else if (req4)           wcnt4 <= wcnt4 + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        repeat (2) tick();
        reset_n = 1'b1;
    endtask

    task automatic fill_nop4();
        for (int i = 0; i < 16; i++) mem4[i] = 8'h80;
    endtask

    task automatic load_basic4();
        fill_nop4();
        mem4[0] = 8'h33;  // MOV A,3
        mem4[1] = 8'h05;  // ADD A,5
        mem4[2] = 8'h40;  // MOV B,A
        mem4[3] = 8'h90;  // OUT B
        mem4[4] = 8'hD0;  // HLT
    endtask

    initial begin
        fill_nop4();
        for (int i = 0; i < 16; i++) mem8[i] = 12'h800;
        mem8[0] = 12'h301;  // MOV A,0x01
        mem8[1] = 12'h0FF;  // ADD A,0xFF
        mem8[2] = 12'hBA5;  // OUT 0xA5
        mem8[3] = 12'h600;  // IN B
        mem8[4] = 12'hD00;  // HLT

        // Reset, then a second reset while a fetch is stalled.
        wait4 = 1000;
        do_reset();
        check("rst_led", led4, 0);
        check("rst_halted", halted4, 0);
        check("rst_req", req4, 1);
        check("rst_addr", addr4, 0);
        repeat (3) tick();
        check("stall_addr", addr4, 0);
        do_reset();
        check("rst2_led", led4, 0);
        check("rst2_halted", halted4, 0);
        check("rst2_req", req4, 1);
        check("rst2_addr", addr4, 0);

        // Basic program, zero-wait; 8-bit instance runs alongside.
        load_basic4();
        wait4 = 0;
        switch8 = 8'h11;
        do_reset();
        repeat (4) tick();
        check("basic_a_after_add", dut4.r_a, 8);
        check("w8_a_after_add", dut8.r_a, 8'h00);
        check("w8_carry_after_add", dut8.r_carry, 1);
        repeat (2) tick();
        check("basic_led_pre", led4, 0);
        check("w8_led", led8, 8'hA5);
        tick();
        switch8 = 8'h3C;
        tick();
        check("basic_led", led4, 8);
        check("w8_b_in", dut8.r_b, 8'h3C);
        tick();
        check("basic_halted_e9", halted4, 0);
        tick();
        check("basic_halted_e10", halted4, 1);
        check("basic_halt_addr", addr4, 4);
        check("basic_halt_req", req4, 0);
        repeat (5) tick();
        check("basic_frozen_halted", halted4, 1);
        check("basic_frozen_addr", addr4, 4);
        check("basic_frozen_req", req4, 0);
        check("basic_frozen_led", led4, 8);

        // Carry handling and JNC.
        fill_nop4();
        mem4[0] = 8'h3F;  // MOV A,0xF
        mem4[1] = 8'h01;  // ADD A,1
        mem4[2] = 8'hE0;  // JNC 0
        mem4[3] = 8'h72;  // MOV B,2
        mem4[4] = 8'hE6;  // JNC 6
        do_reset();
        repeat (4) tick();
        check("carry_a", dut4.r_a, 0);
        check("carry_c", dut4.r_carry, 1);
        repeat (2) tick();
        check("jnc_not_taken_ip", addr4, 3);
        check("jnc_clears_carry", dut4.r_carry, 0);
        repeat (2) tick();
        check("mov_b", dut4.r_b, 2);
        repeat (2) tick();
        check("jnc_taken_ip", addr4, 6);

        // Wait states: three stalled cycles per fetch.
        load_basic4();
        wait4 = 3;
        do_reset();
        for (int i = 1; i <= 3; i++) begin
            tick();
            check("wait_addr", addr4, 0);
            check("wait_req", req4, 1);
            check("wait_a", dut4.r_a, 0);
        end
        tick();
        check("wait_exec_req", req4, 0);
        tick();
        check("wait_a_first", dut4.r_a, 3);
        check("wait_addr_first", addr4, 1);
        repeat (19) tick();
        check("wait_halted_pre", halted4, 0);
        tick();
        check("wait_halted", halted4, 1);
        check("wait_led", led4, 8);
        check("wait_b", dut4.r_b, 8);
        check("wait_addr_final", addr4, 4);

        // IP wrap-around over a NOP-filled memory.
        fill_nop4();
        wait4 = 0;
        do_reset();
        for (int k = 1; k <= 16; k++) begin
            repeat (2) tick();
            check("wrap_ip", addr4, k % 16);
        end
        check("wrap_carry", dut4.r_carry, 0);
        check("wrap_halted", halted4, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
